// File: rtl/oreg_tx_serializer.sv
// rtl/oreg_tx_serializer.sv - captures output-register writes into a FIFO and sends each nibble as a serial frame
// Frame: start(0), 4 data bits LSB first, even parity, stop(1); each bit CLKS_PER_BIT cycles.
module oreg_tx_serializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4
) (
  input  logic                       clk,
  input  logic                       sync_reset,
  input  logic                       o_reg_wr,
  input  logic [3:0]                 o_reg,
  output logic                       tx,
  output logic                       busy,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [3:0]        mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, empty_q, overflow_q;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [1:0]        bit_q, bit_d;
  logic [3:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;

  logic              pop, push, drop, baud_end;

  // A full FIFO still takes a write when the FSM pops on the same edge.
  assign pop      = (state_q == IDLE) && !empty_q;
  assign push     = o_reg_wr && (!full_q || pop);
  assign drop     = o_reg_wr && full_q && !pop;
  assign baud_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CNT_W'(1);
    else if (pop && !push)
      count_d = count_q - CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (pop) begin
          shift_d = mem[rd_ptr_q];
          par_d   = ^mem[rd_ptr_q];
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 2'd0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[3:1]};
          if (bit_q == 2'd3) begin
            state_d = PARITY;
            tx_d    = par_q;
          end else begin
            bit_d = bit_q + 2'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = IDLE;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (drop)
        overflow_q <= 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !sync_reset)
      mem[wr_ptr_q] <= o_reg;
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign full       = full_q;
  assign empty      = empty_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_oreg_tx_serializer.sv
// tb/tb_oreg_tx_serializer.sv - self-checking bench for oreg_tx_serializer
module tb_oreg_tx_serializer;

  localparam int CPB = 4;
  localparam int DEP = 4;
  localparam int MID = CPB / 2;

  logic       clk;
  logic       sync_reset;
  logic       o_reg_wr;
  logic [3:0] o_reg;
  logic       tx, busy, full, empty, overflow;
  logic [2:0] fifo_count;

  oreg_tx_serializer #(.CLKS_PER_BIT(CPB), .DEPTH(DEP)) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .o_reg_wr   (o_reg_wr),
    .o_reg      (o_reg),
    .tx         (tx),
    .busy       (busy),
    .full       (full),
    .empty      (empty),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] val;
    logic       par;
  } vec_t;

  vec_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Frame monitor: samples mid-bit on falling edges and checks against the scoreboard.
  int         cyc = 0;
  bit         mon_active = 0;
  int         mon_idx = 0;
  logic [3:0] mon_d;
  logic       mon_p;
  int         starts[$];

  always @(negedge clk) begin
    vec_t e;
    int   k;
    cyc++;
    if (sync_reset === 1'b1) begin
      mon_active = 0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1;
        mon_idx    = 0;
        starts.push_back(cyc);
        chk("busy_at_start", busy, 1);
      end
    end else begin
      mon_idx++;
      if (mon_idx >= MID && (mon_idx - MID) % CPB == 0) begin
        k = (mon_idx - MID) / CPB;
        if (k == 0) chk("start_bit", tx, 0);
        else if (k <= 4) mon_d = {tx, mon_d[3:1]};
        else if (k == 5) mon_p = tx;
        else begin
          chk("stop_bit", tx, 1);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_frame: got data %0h expected no frame", mon_d);
          end else begin
            e = exp_q.pop_front();
            chk("frame_data", mon_d, e.val);
            chk("frame_parity", mon_p, e.par);
          end
          mon_active = 0;
        end
      end
    end
  end

  task automatic wr(input logic [3:0] v);
    o_reg_wr = 1'b1;
    o_reg    = v;
    @(posedge clk); #1;
    o_reg_wr = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    while (busy && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t vecs[7];
  int   n;
  int   ns;
  vec_t tmp;

  initial begin
    vecs[0] = '{4'hA, 1'b0};
    vecs[1] = '{4'h7, 1'b1};
    vecs[2] = '{4'h0, 1'b0};
    vecs[3] = '{4'h1, 1'b1};
    vecs[4] = '{4'hF, 1'b0};
    vecs[5] = '{4'h6, 1'b0};
    vecs[6] = '{4'h8, 1'b1};

    // Reset with a write present: write must be discarded.
    sync_reset = 1'b1;
    o_reg_wr   = 1'b1;
    o_reg      = 4'h5;
    repeat (3) @(posedge clk);
    #1;
    sync_reset = 1'b0;
    o_reg_wr   = 1'b0;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("rst_no_frame", starts.size(), 0);
    chk("rst_tx_idle", tx, 1);

    // Table: single frames with latency and duration checks.
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(vecs[i]);
      wr(vecs[i].val);
      chk("wr_count", fifo_count, 1);
      chk("wr_empty", empty, 0);
      @(posedge clk); #1;
      chk("pop_tx", tx, 0);
      chk("pop_busy", busy, 1);
      chk("pop_count", fifo_count, 0);
      chk("pop_empty", empty, 1);
      wait_idle(60, n);
      chk("frame_len", n, 7 * CPB);
      chk("end_tx", tx, 1);
      @(posedge clk); #1;
    end

    // Back-to-back frames.
    starts.delete();
    o_reg_wr = 1'b1;
    o_reg = 4'h1; tmp = '{4'h1, ^4'h1}; exp_q.push_back(tmp);
    @(posedge clk); #1;
    chk("b2b_count0", fifo_count, 1);
    o_reg = 4'h2; tmp = '{4'h2, ^4'h2}; exp_q.push_back(tmp);
    @(posedge clk); #1;
    chk("b2b_count1", fifo_count, 1);
    o_reg = 4'h3; tmp = '{4'h3, ^4'h3}; exp_q.push_back(tmp);
    @(posedge clk); #1;
    chk("b2b_count_peak", fifo_count, 2);
    o_reg_wr = 1'b0;
    repeat (56) @(posedge clk);
    #1;
    chk("b2b_before_3rd_count", fifo_count, 1);
    chk("b2b_before_3rd_empty", empty, 0);
    @(posedge clk); #1;
    chk("b2b_after_3rd_count", fifo_count, 0);
    chk("b2b_after_3rd_empty", empty, 1);
    wait_idle(40, n);
    @(posedge clk); #1;
    chk("b2b_frames", starts.size(), 3);
    if (starts.size() == 3) begin
      chk("b2b_gap1", starts[1] - starts[0], 7 * CPB + 1);
      chk("b2b_gap2", starts[2] - starts[1], 7 * CPB + 1);
    end
    chk("b2b_sb_drained", exp_q.size(), 0);

    // Overflow while shifting, then a write on the pop edge of a full FIFO.
    tmp = '{4'h9, 1'b0}; exp_q.push_back(tmp);
    wr(4'h9);
    @(posedge clk); #1;
    o_reg_wr = 1'b1;
    for (int v = 1; v <= 5; v++) begin
      o_reg = 4'(v);
      if (v <= 4) begin
        tmp.val = 4'(v);
        tmp.par = ^tmp.val;
        exp_q.push_back(tmp);
      end
      @(posedge clk); #1;
      if (v == 4) begin
        chk("ovf_full4", full, 1);
        chk("ovf_count4", fifo_count, 4);
        chk("ovf_not_yet", overflow, 0);
      end
    end
    o_reg_wr = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_count", fifo_count, 4);
    chk("ovf_full", full, 1);
    wait_idle(60, n);
    o_reg_wr = 1'b1;
    o_reg    = 4'hC;
    tmp = '{4'hC, 1'b0}; exp_q.push_back(tmp);
    @(posedge clk); #1;
    o_reg_wr = 1'b0;
    chk("fullpop_count", fifo_count, 4);
    chk("fullpop_full", full, 1);
    chk("fullpop_busy", busy, 1);
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ovf_drain_timeout", (n < 300), 1);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_drained_empty", empty, 1);

    // Mid-frame reset.
    @(posedge clk); #1;
    tmp = '{4'h6, 1'b0}; exp_q.push_back(tmp);
    wr(4'h6);
    o_reg_wr = 1'b1;
    o_reg    = 4'h5;
    @(posedge clk); #1;
    o_reg    = 4'h3;
    @(posedge clk); #1;
    o_reg_wr = 1'b0;
    chk("mid_count", fifo_count, 2);
    repeat (5) @(posedge clk);
    #1;
    sync_reset = 1'b1;
    @(posedge clk); #1;
    sync_reset = 1'b0;
    exp_q.delete();
    chk("mid_tx", tx, 1);
    chk("mid_busy", busy, 0);
    chk("mid_empty", empty, 1);
    chk("mid_count0", fifo_count, 0);
    chk("mid_full", full, 0);
    chk("mid_overflow_clr", overflow, 0);
    ns = starts.size();
    repeat (100) @(posedge clk);
    #1;
    chk("mid_no_frame", starts.size(), ns);
    chk("mid_tx_idle", tx, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
